// File: rtl/alu_instr_sequencer.sv
// Multi-cycle R-type instruction sequencer: decode, drive RF read ports and ALU controls, write back once.
// Define SEQ_RETIRE_CNT_EN to add the RetireCount output.
module alu_instr_sequencer #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              InstrValid,
  output logic              InstrReady,
  input  logic [31:0]       Instr,
  output logic [REG_AW-1:0] RR1,
  output logic [REG_AW-1:0] RR2,
  output logic [3:0]        AluOp,
  output logic [4:0]        ShiftCount,
  input  logic [DATA_W-1:0] AluResult,
  output logic [REG_AW-1:0] WR,
  output logic [DATA_W-1:0] WD,
  output logic              WE,
  output logic              Done,
`ifdef SEQ_RETIRE_CNT_EN
  output logic              IllegalOp,
  output logic [31:0]       RetireCount
`else
  output logic              IllegalOp
`endif
);

  localparam int unsigned CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] rr1_q, rr1_d;
  logic [REG_AW-1:0] rr2_q, rr2_d;
  logic [REG_AW-1:0] wr_q, wr_d;
  logic [3:0]        op_q, op_d;
  logic [4:0]        sc_q, sc_d;
  logic [DATA_W-1:0] wd_q, wd_d;
`ifdef SEQ_RETIRE_CNT_EN
  logic [31:0]       retire_q, retire_d;
`endif

  logic [5:0] f_op, f_funct;
  logic [4:0] f_rs, f_rt, f_rd, f_shamt;

  assign f_op    = instr_q[31:26];
  assign f_rs    = instr_q[25:21];
  assign f_rt    = instr_q[20:16];
  assign f_rd    = instr_q[15:11];
  assign f_shamt = instr_q[10:6];
  assign f_funct = instr_q[5:0];

  logic       dec_known;
  logic       dec_shift;
  logic [3:0] dec_aluop;
  logic       dec_legal;

  always_comb begin
    dec_known = 1'b1;
    dec_shift = 1'b0;
    dec_aluop = '0;
    case (f_funct)
      6'h20: dec_aluop = 4'b0010;
      6'h22: dec_aluop = 4'b0110;
      6'h24: dec_aluop = 4'b0000;
      6'h25: dec_aluop = 4'b0001;
      6'h27: dec_aluop = 4'b1100;
      6'h2A: dec_aluop = 4'b0111;
      6'h00: begin dec_aluop = 4'b1110; dec_shift = 1'b1; end
      6'h02: begin dec_aluop = 4'b1101; dec_shift = 1'b1; end
      6'h03: begin dec_aluop = 4'b1111; dec_shift = 1'b1; end
      default: dec_known = 1'b0;
    endcase
  end

  assign dec_legal = (f_op == '0) && dec_known;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    cnt_d      = cnt_q;
    rr1_d      = rr1_q;
    rr2_d      = rr2_q;
    wr_d       = wr_q;
    op_d       = op_q;
    sc_d       = sc_q;
    wd_d       = wd_q;
`ifdef SEQ_RETIRE_CNT_EN
    retire_d   = retire_q;
`endif
    InstrReady = 1'b0;
    WE         = 1'b0;
    Done       = 1'b0;
    IllegalOp  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // State resets to IDLE asynchronously, so readiness must also be masked by Rst.
        InstrReady = !Rst;
        if (InstrValid) begin
          instr_d = Instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          Done      = 1'b1;
          IllegalOp = 1'b1;
          state_d   = S_IDLE;
        end else begin
          rr1_d   = dec_shift ? REG_AW'(f_rt) : REG_AW'(f_rs);
          rr2_d   = REG_AW'(f_rt);
          op_d    = dec_aluop;
          sc_d    = dec_shift ? f_shamt : 5'd0;
          cnt_d   = '0;
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (cnt_q == CNT_LAST) begin
          wd_d    = AluResult;
          wr_d    = REG_AW'(f_rd);
          state_d = S_WRITEBACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITEBACK: begin
        Done    = 1'b1;
        WE      = (wr_q != '0);
        state_d = S_IDLE;
`ifdef SEQ_RETIRE_CNT_EN
        if (wr_q != '0) retire_d = retire_q + 32'd1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      cnt_q    <= '0;
      rr1_q    <= '0;
      rr2_q    <= '0;
      wr_q     <= '0;
      op_q     <= '0;
      sc_q     <= '0;
      wd_q     <= '0;
`ifdef SEQ_RETIRE_CNT_EN
      retire_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      rr1_q    <= rr1_d;
      rr2_q    <= rr2_d;
      wr_q     <= wr_d;
      op_q     <= op_d;
      sc_q     <= sc_d;
      wd_q     <= wd_d;
`ifdef SEQ_RETIRE_CNT_EN
      retire_q <= retire_d;
`endif
    end
  end

  assign RR1        = rr1_q;
  assign RR2        = rr2_q;
  assign AluOp      = op_q;
  assign ShiftCount = sc_q;
  assign WR         = wr_q;
  assign WD         = wd_q;
`ifdef SEQ_RETIRE_CNT_EN
  assign RetireCount = retire_q;
`endif

endmodule
